pwm_capture: RTL and testbench

- PWM receiver and duty-cycle decoder. It is the counterpart to the 6-bit PWM LED generator on the same TinyTapeout I/O style.
- Samples a single asynchronous PWM input and measures the high time and the period of each cycle.
- Reports the measured width, the period and stuck-level flags, plus a thermometer LED bar, so a generator output can be looped back and checked on-chip.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 158 +++++++++++++++
 tb/tb_pwm_capture.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: FSM states, default sizing and
// the saturation / thermometer helpers also used by the generator's LED logic.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

    localparam int unsigned PWM_WIDTH   = 6;
    localparam int unsigned PWM_TIMEOUT = 128;

    function automatic int unsigned sat_u(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

    // Thermometer code with `level` LSBs set.
    function automatic logic [7:0] therm8(input logic [2:0] level);
        logic [7:0] one_hot;
        one_hot = 8'd1 << level;
        return one_hot - 8'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for the asynchronous PWM pin plus rise/fall detection
// on the synchronized level.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pwm_s = r_sync[SYNC_STAGES-1];
    assign rise  = pwm_s & ~r_pwm_d;
    assign fall  = ~pwm_s & r_pwm_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of each cycle of an asynchronous
// input, flags a stuck level after TIMEOUT idle cycles and drives an LED bar.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = PWM_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] width_out,
    output logic [WIDTH:0]   period_out,
    output logic             valid,
    output logic             stuck_hi,
    output logic             stuck_lo,
    output logic [7:0]       bar_out
);

    localparam int unsigned      CNT_W    = WIDTH + 2;
    localparam int unsigned      HCNT_W   = WIDTH + 1;
    localparam int unsigned      W_MAX    = (1 << WIDTH) - 1;
    localparam int unsigned      P_MAX    = (1 << (WIDTH + 1)) - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic w_pwm_s;
    logic w_rise;
    logic w_fall;
    logic w_timeout;
    logic w_do_latch;
    logic w_do_timeout;

    pwm_state_e        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [HCNT_W-1:0] r_hcnt, w_hcnt_next;
    logic [WIDTH-1:0]  r_width, w_width_next;
    logic [WIDTH:0]    r_period, w_period_next;
    logic              r_valid, w_valid_next;
    logic              r_stuck_hi, w_stuck_hi_next;
    logic              r_stuck_lo, w_stuck_lo_next;
    logic [7:0]        r_bar, w_bar_next;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .pwm_s (w_pwm_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Any detected edge suppresses the timeout; >= keeps the count bounded if a
    // fall lands exactly on the last count.
    assign w_timeout = (r_cnt >= CNT_LAST) && !(w_rise || w_fall);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_hcnt_next  = r_hcnt;
        w_do_latch   = 1'b0;
        w_do_timeout = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                    w_cnt_next   = CNT_W'(1);
                    w_hcnt_next  = HCNT_W'(1);
                end else if (w_timeout) begin
                    w_do_timeout = 1'b1;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_next = LOW;
                end else if (w_timeout) begin
                    w_do_timeout = 1'b1;
                end else begin
                    w_hcnt_next = r_hcnt + 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_do_latch   = 1'b1;
                    w_state_next = HIGH;
                    w_cnt_next   = CNT_W'(1);
                    w_hcnt_next  = HCNT_W'(1);
                end else if (w_timeout) begin
                    w_do_timeout = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_do_timeout) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_hcnt_next  = '0;
        end
    end

    // A timeout in HIGH always sees pwm_s high and in LOW always low, so the
    // synchronized level alone selects the stuck flavour in every state.
    always_comb begin
        w_width_next    = r_width;
        w_period_next   = r_period;
        w_stuck_hi_next = r_stuck_hi;
        w_stuck_lo_next = r_stuck_lo;
        w_valid_next    = w_do_latch | w_do_timeout;
        if (w_do_latch) begin
            w_width_next    = WIDTH'(sat_u(32'(r_hcnt), W_MAX));
            w_period_next   = (WIDTH + 1)'(sat_u(32'(r_cnt), P_MAX));
            w_stuck_hi_next = 1'b0;
            w_stuck_lo_next = 1'b0;
        end else if (w_do_timeout) begin
            w_width_next    = w_pwm_s ? WIDTH'(W_MAX) : '0;
            w_period_next   = '0;
            w_stuck_hi_next = w_pwm_s;
            w_stuck_lo_next = ~w_pwm_s;
        end
        w_bar_next = w_stuck_hi_next ? 8'hFF : therm8(3'(w_width_next >> (WIDTH - 3)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_width    <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
            r_bar      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_hcnt     <= w_hcnt_next;
            r_width    <= w_width_next;
            r_period   <= w_period_next;
            r_valid    <= w_valid_next;
            r_stuck_hi <= w_stuck_hi_next;
            r_stuck_lo <= w_stuck_lo_next;
            r_bar      <= w_bar_next;
        end
    end

    assign width_out  = r_width;
    assign period_out = r_period;
    assign valid      = r_valid;
    assign stuck_hi   = r_stuck_hi;
    assign stuck_lo   = r_stuck_lo;
    assign bar_out    = r_bar;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: an edge-time model checked against every output each
// cycle, plus literal expectations after directed PWM sequences.
module tb_pwm_capture;

    localparam int unsigned WIDTH       = 6;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [WIDTH-1:0] width_out;
    logic [WIDTH:0]   period_out;
    logic             valid;
    logic             stuck_hi;
    logic             stuck_lo;
    logic [7:0]       bar_out;

    pwm_capture #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .width_out (width_out),
        .period_out(period_out),
        .valid     (valid),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo),
        .bar_out   (bar_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: works on pin-sample history and the clock-edge index of each
    // synchronized edge; results come from edge-time differences.
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    logic ms, md;
    int   edge_n = 0;
    bit   have_rise = 1'b0;
    int   rise_n = 0, fall_n = 0;
    int   deadline = TIMEOUT;
    int   m_width = 0, m_period = 0;
    bit   m_valid = 1'b0, m_hi = 1'b0, m_lo = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
            edge_n = 0; have_rise = 1'b0; deadline = TIMEOUT;
            m_width = 0; m_period = 0; m_valid = 1'b0; m_hi = 1'b0; m_lo = 1'b0;
        end else begin
            edge_n++;
            ms = h1;
            md = h2;
            m_valid = 1'b0;
            if (ms && !md) begin
                if (have_rise) begin
                    m_width  = (fall_n - rise_n > 63) ? 63 : fall_n - rise_n;
                    m_period = (edge_n - rise_n > 127) ? 127 : edge_n - rise_n;
                    m_hi = 1'b0; m_lo = 1'b0; m_valid = 1'b1;
                end
                have_rise = 1'b1;
                rise_n    = edge_n;
                deadline  = edge_n + TIMEOUT - 1;
            end else if (!ms && md) begin
                fall_n = edge_n;
            end else if (edge_n >= deadline) begin
                m_valid  = 1'b1;
                m_period = 0;
                m_width  = ms ? 63 : 0;
                m_hi     = ms;
                m_lo     = !ms;
                have_rise = 1'b0;
                deadline  = edge_n + TIMEOUT;
            end
            h2 = h1; h1 = h0; h0 = pwm_in;
        end
    end

    int v_cnt = 0;
    int vn[$];
    int cap_w = 0, cap_p = 0, cap_hi = 0, cap_lo = 0, cap_bar = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_width", int'(width_out), 0);
            check("rst_period", int'(period_out), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_stuck", int'({stuck_hi, stuck_lo}), 0);
            check("rst_bar", int'(bar_out), 0);
        end else begin
            check("width", int'(width_out), m_width);
            check("period", int'(period_out), m_period);
            check("valid", int'(valid), int'(m_valid));
            check("stuck_hi", int'(stuck_hi), int'(m_hi));
            check("stuck_lo", int'(stuck_lo), int'(m_lo));
            check("bar", int'(bar_out), m_hi ? 255 : (1 << (m_width / 8)) - 1);
        end
        if (valid) begin
            v_cnt++;
            vn.push_back(edge_n);
            cap_w = int'(width_out); cap_p = int'(period_out);
            cap_hi = int'(stuck_hi); cap_lo = int'(stuck_lo); cap_bar = int'(bar_out);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            tick(1);
        end
    endtask

    task automatic expect_cap(input string name, input int w, input int p, input int hi,
                              input int lo, input int bar);
        check({name, "_width"}, cap_w, w);
        check({name, "_period"}, cap_p, p);
        check({name, "_hi"}, cap_hi, hi);
        check({name, "_lo"}, cap_lo, lo);
        check({name, "_bar"}, cap_bar, bar);
    endtask

    int v0, e0, base;

    initial begin
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pwm_in = ~pwm_in;
            tick(1);
        end
        check("reset_no_valid", v_cnt, 0);
        pwm_in = 1'b0;
        rst    = 1'b1;

        // Input held low from reset: stuck_lo every TIMEOUT cycles.
        base = vn.size();
        tick(300);
        check("low_valid_count", vn.size() - base, 2);
        if (vn.size() - base == 2) begin
            check("low_first_edge", vn[base], 128);
            check("low_second_edge", vn[base+1], 256);
        end
        expect_cap("stuck_lo", 0, 0, 0, 1, 0);

        // 16/64 for three periods: results on the 2nd and 3rd rises.
        v0 = v_cnt;
        run(16, 64);
        run(16, 64);
        e0 = edge_n;
        run(16, 64);
        check("p64_valid_count", v_cnt - v0, 2);
        check("p64_latency", vn[vn.size()-1] - e0, 3);
        expect_cap("p64h16", 16, 64, 0, 0, 8'b0000_0011);

        run(63, 64);
        run(1, 100);
        expect_cap("p64h63", 63, 64, 0, 0, 8'b0111_1111);
        run(20, 50);
        expect_cap("p100h1", 1, 100, 0, 0, 0);

        // High longer than the width range saturates without timing out.
        run(80, 120);
        run(10, 30);
        expect_cap("sat", 63, 120, 0, 0, 8'b0111_1111);

        // Held high from a rise: timeout 130 edges after the pin is driven high.
        run(20, 40);
        run(20, 40);
        e0 = edge_n;
        v0 = v_cnt;
        pwm_in = 1'b1;
        tick(140);
        check("hi_valid_count", v_cnt - v0, 2);
        check("hi_timeout_edge", vn[vn.size()-1] - e0, 130);
        expect_cap("stuck_hi", 63, 0, 1, 0, 255);

        pwm_in = 1'b0;
        tick(10);
        v0 = v_cnt;
        run(20, 40);
        check("recover_first_rise", v_cnt - v0, 0);
        run(20, 40);
        check("recover_second_rise", v_cnt - v0, 1);
        expect_cap("recover", 20, 40, 0, 0, 8'b0000_0011);

        // Reset asserted mid-HIGH clears outputs without waiting for a clock.
        run(16, 64);
        pwm_in = 1'b1;
        tick(5);
        #2 rst = 1'b0;
        #1;
        check("async_width", int'(width_out), 0);
        check("async_period", int'(period_out), 0);
        check("async_bar", int'(bar_out), 0);
        pwm_in = 1'b0;
        tick(3);
        rst = 1'b1;
        v0 = v_cnt;
        run(16, 64);
        check("post_rst_first_rise", v_cnt - v0, 0);
        run(16, 64);
        check("post_rst_second_rise", v_cnt - v0, 1);
        expect_cap("post_rst", 16, 64, 0, 0, 8'b0000_0011);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
